// File: rtl/fdiv_seq.sv
// fdiv_seq: sequential floating-point divider, y = x1 / x2.
// Radix-2 restoring mantissa division, one quotient bit per cycle, followed by
// a single round-to-nearest-even cycle. Operands are normal numbers or +0
// (exponent field 0). Latency is fixed at FRAC_W+4 edges from accept.
//
// Ports:
//   clk       clock, rising edge
//   rstn      synchronous active-low reset
//   in_valid  operands x1/x2 valid
//   in_ready  block accepts operands this cycle
//   x1, x2    dividend, divisor ({sign, exponent, fraction})
//   out_valid result valid (held until out_ready)
//   out_ready consumer takes the result this cycle
//   y         quotient
//   ovf       exponent overflow or underflow
//   dz        divide by zero
module fdiv_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   x1,
  input  logic [EXP_W+FRAC_W:0]   x2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   y,
  output logic                    ovf,
  output logic                    dz
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int N     = FRAC_W + 3;
  localparam int CNT_W = $clog2(N + 1);
  localparam int EW    = EXP_W + 2;

  localparam logic [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0] E_ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t              r_state;
  logic                r_s;
  logic [EXP_W-1:0]    r_e1;
  logic [EXP_W-1:0]    r_e2;
  logic [FRAC_W:0]     r_mb;
  logic [FRAC_W+1:0]   r_r;
  logic [N-1:0]        r_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [W-1:0]        r_y;
  logic                r_ovf;
  logic                r_dz;

  logic                w_accept;
  logic                w_ge;
  logic [FRAC_W+1:0]   w_rdiff;
  logic [EW-1:0]       w_ebase;
  logic [EW-1:0]       w_eadj;
  logic [EW-1:0]       w_efin;
  logic [FRAC_W-1:0]   w_frac_pre;
  logic                w_g;
  logic                w_st;
  logic                w_inc;
  logic [FRAC_W:0]     w_fsum;
  logic [W-1:0]        w_y;
  logic                w_ovf;
  logic                w_dz;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign dz        = r_dz;

  // One restoring-division step.
  always_comb begin
    w_ge    = (r_r >= {1'b0, r_mb});
    w_rdiff = w_ge ? (r_r - {1'b0, r_mb}) : r_r;
  end

  // Normalise, round and apply special-case overrides.
  // The hidden bit is always 1, so a carry out of the fraction add is the
  // same as a carry out of the full significand.
  always_comb begin
    w_ebase = {2'b00, r_e1} - {2'b00, r_e2} + BIAS;
    if (r_q[N-1]) begin
      w_frac_pre = r_q[N-2:2];
      w_g        = r_q[1];
      w_st       = r_q[0] | (|r_r);
      w_eadj     = w_ebase;
    end else begin
      w_frac_pre = r_q[N-3:1];
      w_g        = r_q[0];
      w_st       = |r_r;
      w_eadj     = w_ebase - E_ONE;
    end
    w_inc  = w_g & (w_st | w_frac_pre[0]);
    w_fsum = {1'b0, w_frac_pre} + {{FRAC_W{1'b0}}, w_inc};
    w_efin = w_fsum[FRAC_W] ? (w_eadj + E_ONE) : w_eadj;

    w_y   = '0;
    w_ovf = 1'b0;
    w_dz  = 1'b0;
    if (r_e1 == '0) begin
      w_y = '0;
    end else if (r_e2 == '0) begin
      w_y  = {r_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_dz = 1'b1;
    end else if (!w_efin[EW-1] && (w_efin >= EMAX)) begin
      w_y   = {r_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_ovf = 1'b1;
    end else if (w_efin[EW-1] || (w_efin == '0)) begin
      w_ovf = 1'b1;
    end else begin
      w_y = {r_s, w_efin[EXP_W-1:0], w_fsum[FRAC_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_s     <= 1'b0;
      r_e1    <= '0;
      r_e2    <= '0;
      r_mb    <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      unique case (r_state)
        CALC: begin
          r_q   <= {r_q[N-2:0], w_ge};
          r_r   <= w_rdiff << 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ROUND;
        end
        ROUND: begin
          r_y     <= w_y;
          r_ovf   <= w_ovf;
          r_dz    <= w_dz;
          r_state <= DONE;
        end
        default: ;
      endcase

      // Accept is only possible from IDLE or DONE, so it never collides
      // with the CALC/ROUND updates above.
      if (w_accept) begin
        r_s     <= x1[W-1] ^ x2[W-1];
        r_e1    <= x1[W-2:FRAC_W];
        r_e2    <= x2[W-2:FRAC_W];
        r_mb    <= {1'b1, x2[FRAC_W-1:0]};
        r_r     <= {2'b01, x1[FRAC_W-1:0]};
        r_q     <= '0;
        r_cnt   <= CNT_W'(N);
        r_state <= CALC;
      end else if ((r_state == DONE) && out_ready) begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

Parametrised, sequential floating-point divider, the successor to the combinational reciprocal-then-multiply divider. It computes `x1 / x2` using radix-2 restoring mantissa division, one quotient bit per cycle, with round-to-nearest-even. Inputs and outputs use valid/ready handshakes, so the block sits directly in the FPU issue/writeback path and stalls cleanly under back-pressure. It also reports overflow/underflow and divide-by-zero.

## Interface
- `EXP_W`, default 8: exponent width.
- `FRAC_W`, default 23: fraction width. The word width `W = 1+EXP_W+FRAC_W`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rstn` in 1: reset. One clock; reset is synchronous and active-low.
- `in_valid` in 1: operands `x1`, `x2` are valid.
- `in_ready` out 1: the block accepts operands this cycle.
- `x1` in W: dividend.
- `x2` in W: divisor.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer takes the result this cycle.
- `y` out W: quotient.
- `ovf` out 1: overflow or underflow (one flag for both).
- `dz` out 1: divide by zero.

## Operation
- Operand model:
  - Inputs are never denormal, NaN or inf.
  - An exponent field of 0 means +0, whatever the fraction.
  - `BIAS = 2^(EXP_W-1)-1`.
- FSM states: IDLE, CALC, ROUND, DONE.
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - `out_valid = (state==DONE)`.
- Accept (`in_valid && in_ready`):
  - Latch `s = s1^s2`, both exponents, `ma = {1,f1}` and `mb = {1,f2}`.
  - Set remainder `r = ma` (FRAC_W+2 bits), clear `q`, load counter with `N = FRAC_W+3`, and go to CALC.
- CALC, each cycle:
  - If `r >= mb`: `qbit = 1` and `r = r - mb`; else `qbit = 0`.
  - Then `q = {q, qbit}`, `r = r << 1`, and decrement the counter.
  - Go to ROUND after N cycles. The first bit has weight 2^0, so `q` lies in (0.5, 2).
- ROUND, one cycle:
  - Exponent arithmetic is signed, EXP_W+2 bits: `e = e1 - e2 + BIAS`.
  - If `q[N-1]`: significand = `q[N-1:2]`, guard = `q[1]`, sticky = `q[0] | (r!=0)`.
  - Else: significand = `q[N-2:1]`, guard = `q[0]`, sticky = `(r!=0)`, and `e = e - 1`.
  - RNE: increment when `guard & (sticky | sig[0])`. On carry-out, the significand becomes `1.000…` and `e = e + 1`.
  - Result override, in priority order:
    - `x1` exponent 0: `y = 0`, `ovf = 0`, `dz = 0`. This includes 0/0.
    - `x2` exponent 0: `y = {s, all-ones exp, 0 frac}`, `dz = 1`, `ovf = 0`.
    - `e >= 2^EXP_W-1`: `y = {s, all-ones, 0}`, `ovf = 1`.
    - `e <= 0`: `y = 0` (+0), `ovf = 1`.
    - Otherwise: `y = {s, e[EXP_W-1:0], frac}`.
  - Go to DONE.
- DONE:
  - `y`, `ovf` and `dz` stay stable while `out_valid && !out_ready`.
  - On `out_ready`: if a new operand is accepted in the same cycle, go to CALC; else go to IDLE.
- Zero and divide-by-zero cases still run all N CALC cycles. Latency is fixed.

## Timing
- Latency: `out_valid` rises FRAC_W+4 edges after the accepting edge, which is 27 edges for the default.
- Throughput: one result per FRAC_W+5 cycles with `out_ready` held high. Back-to-back issue is allowed through DONE→CALC.
- Reset:
  - While `rstn` is low at an edge, the state goes to IDLE, `y = 0`, `ovf = 0`, `dz = 0`, `out_valid = 0`, and `q`, `r` and the counter clear.
  - `in_ready` is 1 from the first post-reset cycle.
  - A reset mid-CALC or in DONE discards the operation with no output.
- `in_valid` is ignored while `in_ready` is 0. Operands need only be stable in the accepting cycle.

## Test plan
- 6.0/2.0: `0x40C00000 / 0x40000000` → `y = 0x40400000`, `ovf = 0`, `dz = 0`, `out_valid` exactly 27 edges after accept.
- 1/3 rounding: `0x3F800000 / 0x40400000` → `0x3EAAAAAB`. Also -1/3: `0xBF800000 / 0x40400000` → `0xBEAAAAAB`.
- Range limits:
  - `0x7F000000 / 0x00800000` → `ovf = 1`, `y = 0x7F800000`.
  - `0x00800000 / 0x7F000000` → `ovf = 1`, `y = 0x00000000`.
- Zero cases:
  - `0x3F800000 / 0x00000000` → `dz = 1`, `y = 0x7F800000`.
  - `0x00000000 / 0x40000000` → `y = 0`, all flags 0.
- Back-pressure and back-to-back:
  - Hold `out_ready = 0` for 10 cycles: `y` is stable and `in_ready = 0`.
  - Then assert `out_ready` with a new `in_valid` in the same cycle: the next operand is accepted without an IDLE cycle.
- Reset mid-op: assert `rstn = 0` for one edge at CALC cycle 10 → `out_valid` never rises for that op, and a fresh 6.0/2.0 after reset gives `0x40400000`.
